piso_shift_tx: RTL and testbench

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/piso_shift_tx.sv | 128 ++++++++++++
 tb/tb_piso_shift_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// Purpose: parallel-in serial-out transmitter with a one-word holding buffer so words stream back-to-back.
// Latency: first serial bit is presented right after the accepting falling edge; one bit per clock after that.
// Backpressure: in_ready drops while the holding buffer is full and for the single warm-up cycle after reset.
//
// Ports:
//   clk       clock; every register updates on the falling edge
//   rst       synchronous, active-high reset
//   in_valid  parallel word offered          in_data  parallel word (WIDTH bits)
//   in_ready  word can be accepted this cycle (depends on registered state only)
//   ser_out   current serial bit             ser_valid  ser_out carries a data bit
//   ser_last  ser_out is the final bit of its word
//   busy      a word is shifting or waiting in the holding buffer
module piso_shift_tx #(
  parameter int WIDTH     = 32,  // 2..64
  parameter int MSB_FIRST = 1    // 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;
  logic [CW-1:0]    cnt;
  logic             xfer;
  logic             shifting;
  logic             cnt_zero;
  logic             tx_bit;

  assign shifting = (state == ST_SHIFT);
  assign cnt_zero = (cnt == '0);

  // Ready is a pure function of registered state so upstream never sees a
  // combinational path from its own in_valid back to in_ready.
  assign in_ready = (state != ST_WARMUP) && !buf_full;
  assign xfer     = in_valid && in_ready;

  // The outgoing bit always sits at one end of the shifter; the shifter is
  // moved towards that end after each bit.
  assign tx_bit = (MSB_FIRST != 0) ? shifter[WIDTH-1] : shifter[0];

  always_comb begin
    shifted = shifter;
    if (MSB_FIRST != 0) begin
      shifted = {shifter[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shifter[WIDTH-1:1]};
    end
  end

  // Outputs are gated by the SHIFT state so IDLE/WARMUP always show zeros,
  // whatever residue the shifter holds.
  assign ser_valid = shifting;
  assign ser_out   = shifting && tx_bit;
  assign ser_last  = shifting && cnt_zero;
  assign busy      = shifting || buf_full;

  always_ff @(negedge clk) begin
    if (rst) begin
      state    <= ST_WARMUP;
      shifter  <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_WARMUP: begin
          state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (xfer) begin
            shifter <= in_data;
            cnt     <= CW'(WIDTH - 1);
            state   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (!cnt_zero) begin
            shifter <= shifted;
            cnt     <= cnt - CW'(1);
            // in_ready already excludes a full buffer, so xfer here means
            // the buffer is free to take the next word.
            if (xfer) begin
              buf_data <= in_data;
              buf_full <= 1'b1;
            end
          end else begin
            // Edge ending the last bit: chain the next word with no gap,
            // preferring the buffered word (in_ready is low when it is full).
            if (buf_full) begin
              shifter  <= buf_data;
              buf_full <= 1'b0;
              cnt      <= CW'(WIDTH - 1);
            end else if (xfer) begin
              shifter <= in_data;
              cnt     <= CW'(WIDTH - 1);
            end else begin
              shifter <= '0;
              state   <= ST_IDLE;
            end
          end
        end

        default: begin
          state <= ST_WARMUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: three instances (8-bit MSB-first, 8-bit LSB-first, 32-bit MSB-first).
// Stimulus pushes the expected serial bits when a word is accepted; per-instance monitors pop
// and compare every cycle, also checking ser_valid/busy against the scoreboard occupancy.
module tb_piso_shift_tx;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk;

  // instance a: WIDTH=8, MSB_FIRST=1
  logic       rst_a, v_a, rdy_a, so_a, sv_a, sl_a, b_a;
  logic [7:0] d_a;
  // instance b: WIDTH=8, MSB_FIRST=0
  logic       rst_b, v_b, rdy_b, so_b, sv_b, sl_b, b_b;
  logic [7:0] d_b;
  // instance c: WIDTH=32, MSB_FIRST=1
  logic        rst_c, v_c, rdy_c, so_c, sv_c, sl_c, b_c;
  logic [31:0] d_c;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int checks;
  int failures;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst_a), .in_valid(v_a), .in_data(d_a), .in_ready(rdy_a),
    .ser_out(so_a), .ser_valid(sv_a), .ser_last(sl_a), .busy(b_a)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(v_b), .in_data(d_b), .in_ready(rdy_b),
    .ser_out(so_b), .ser_valid(sv_b), .ser_last(sl_b), .busy(b_b)
  );

  piso_shift_tx #(.WIDTH(32), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst_c), .in_valid(v_c), .in_data(d_c), .in_ready(rdy_c),
    .ser_out(so_c), .ser_valid(sv_c), .ser_last(sl_c), .busy(b_c)
  );

  // First transition is a falling edge at t=5 (the DUT's active edge); posedges sit mid-cycle.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus acts 1 time unit after the posedge, so the monitors always sample first.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic get_rdy(input int inst);
    case (inst)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  task automatic set_in(input int inst, input logic v, input logic [63:0] w);
    case (inst)
      0: begin v_a = v; d_a = w[7:0]; end
      1: begin v_b = v; d_b = w[7:0]; end
      default: begin v_c = v; d_c = w[31:0]; end
    endcase
  endtask

  // seq holds the bits in emission order: bit wid-1 of seq is the first bit on the wire.
  task automatic push_exp(input int inst, input logic [63:0] seq);
    int   wid;
    exp_t e;
    wid = (inst == 2) ? 32 : 8;
    for (int i = 0; i < wid; i++) begin
      e.b    = seq[wid-1-i];
      e.last = (i == wid - 1);
      case (inst)
        0:       qa.push_back(e);
        1:       qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  // Holds in_valid with word w until accepted; returns one tick after the accepting edge
  // with in_valid still high. stalls counts cycles spent waiting for in_ready.
  task automatic offer(input int inst, input logic [63:0] w, input logic [63:0] seq,
                       output int stalls);
    bit done;
    done   = 0;
    stalls = 0;
    set_in(inst, 1'b1, w);
    for (int k = 0; k < 200 && !done; k++) begin
      if (get_rdy(inst)) begin
        push_exp(inst, seq);
        done = 1;
      end else begin
        stalls++;
      end
      tick();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout inst=%0d word=%0h: not accepted in 200 cycles, expected acceptance", inst, w);
    end
  endtask

  task automatic drain(input int inst);
    int k;
    for (k = 0; k < 200; k++) begin
      if (qsize(inst) == 0) break;
      tick();
    end
    if (k == 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout inst=%0d: %0d bits still expected after 200 cycles", inst, qsize(inst));
    end
  endtask

  // Every accepted-but-unfinished word has bits in the queue, and the DUT
  // never idles while one exists, so occupancy predicts ser_valid and busy.
  task automatic mon(input int inst, input logic v, input logic o, input logic l, input logic b);
    string tag;
    int    sz;
    exp_t  e;
    tag = (inst == 0) ? "a" : (inst == 1) ? "b" : "c";
    sz  = qsize(inst);
    chk({tag, "_ser_valid"}, 64'(v), 64'(sz != 0));
    chk({tag, "_busy"}, 64'(b), 64'(sz != 0));
    if (v && sz != 0) begin
      case (inst)
        0:       e = qa.pop_front();
        1:       e = qb.pop_front();
        default: e = qc.pop_front();
      endcase
      chk({tag, "_ser_out"}, 64'(o), 64'(e.b));
      chk({tag, "_ser_last"}, 64'(l), 64'(e.last));
    end else if (!v) begin
      chk({tag, "_idle_ser_out"}, 64'(o), 64'd0);
      chk({tag, "_idle_ser_last"}, 64'(l), 64'd0);
    end
  endtask

  always @(posedge clk) mon(0, sv_a, so_a, sl_a, b_a);
  always @(posedge clk) mon(1, sv_b, so_b, sl_b, b_b);
  always @(posedge clk) mon(2, sv_c, so_c, sl_c, b_c);

  initial begin
    int st;
    int k;
    logic [31:0] w;
    int gap;

    checks   = 0;
    failures = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    set_in(0, 1'b0, 64'd0);
    set_in(1, 1'b0, 64'd0);
    set_in(2, 1'b0, 64'd0);

    // Reset state
    tick();
    tick();
    chk("reset_in_ready", 64'(rdy_a), 64'd0);
    chk("reset_busy", 64'(b_a), 64'd0);
    chk("reset_ser_valid", 64'(sv_a), 64'd0);

    // 0xA5 offered as reset releases: one WARMUP stall, then 1,0,1,0,0,1,0,1
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    chk("warmup_in_ready", 64'(rdy_a), 64'd0);
    offer(0, 64'hA5, 64'b1010_0101, st);
    chk("warmup_stalls", 64'(st), 64'd1);
    set_in(0, 1'b0, 64'd0);
    drain(0);
    tick();
    chk("a5_after_ser_valid", 64'(sv_a), 64'd0);
    chk("a5_after_busy", 64'(b_a), 64'd0);

    // 0x3C then 0xC3 back-to-back: 16 contiguous bits, buffer blocks in_ready
    offer(0, 64'h3C, 64'b0011_1100, st);
    offer(0, 64'hC3, 64'b1100_0011, st);
    chk("b2b_second_stalls", 64'(st), 64'd0);
    set_in(0, 1'b0, 64'd0);
    chk("buf_full_in_ready", 64'(rdy_a), 64'd0);
    chk("buf_full_busy", 64'(b_a), 64'd1);
    tick();
    chk("buf_full_in_ready_2", 64'(rdy_a), 64'd0);
    drain(0);
    tick();

    // 0x00, then 0xFF offered only during its last bit: direct load, no gap
    offer(0, 64'h00, 64'b0000_0000, st);
    set_in(0, 1'b0, 64'd0);
    for (k = 0; k < 20; k++) begin
      if (sl_a) break;
      tick();
    end
    chk("last_bit_reached", 64'(k < 20), 64'd1);
    chk("last_bit_in_ready", 64'(rdy_a), 64'd1);
    offer(0, 64'hFF, 64'b1111_1111, st);
    chk("direct_load_stalls", 64'(st), 64'd0);
    set_in(0, 1'b0, 64'd0);
    drain(0);
    tick();

    // LSB-first 0x01 -> 1 then seven 0s
    offer(1, 64'h01, 64'b1000_0000, st);
    set_in(1, 1'b0, 64'd0);
    drain(1);
    tick();

    // Reset at bit 4 of 0xF0 with 0x0F buffered: everything discarded
    offer(0, 64'hF0, 64'b1111_0000, st);
    offer(0, 64'h0F, 64'b0000_1111, st);
    set_in(0, 1'b0, 64'd0);
    tick();
    tick();
    rst_a = 1'b1;
    qa.delete();
    tick();
    chk("rst_mid_ser_valid", 64'(sv_a), 64'd0);
    chk("rst_mid_ser_out", 64'(so_a), 64'd0);
    chk("rst_mid_ser_last", 64'(sl_a), 64'd0);
    chk("rst_mid_busy", 64'(b_a), 64'd0);
    chk("rst_mid_in_ready", 64'(rdy_a), 64'd0);
    rst_a = 1'b0;
    chk("rst_mid_warmup_in_ready", 64'(rdy_a), 64'd0);
    tick();
    chk("rst_mid_idle_in_ready", 64'(rdy_a), 64'd1);
    repeat (12) tick();

    // 32-bit random traffic, mixed back-to-back and gapped
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      offer(2, 64'(w), 64'(w), st);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        set_in(2, 1'b0, 64'd0);
        repeat (gap) tick();
      end
    end
    set_in(2, 1'b0, 64'd0);
    drain(2);
    tick();
    chk("c_final_busy", 64'(b_c), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
